// File: rtl/uart_framed_if.sv
// Handshake and serial-line bundle for uart_framed: TX send request, RX FIFO read port, pins.
// The DUT takes the slave side; the driver of sends and pops takes the master side.
interface uart_framed_if #(
    parameter int unsigned DataWidth = 8
);
    logic [DataWidth-1:0] tx_data;
    logic                 tx_send;
    logic                 tx_busy;
    logic                 tx;
    logic                 rx;
    logic [DataWidth-1:0] rx_data;
    logic                 rx_parity_error;
    logic                 rx_framing_error;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_overflow;

    modport master (
        output tx_data, tx_send, rx, rx_ready,
        input  tx_busy, tx, rx_data, rx_parity_error, rx_framing_error, rx_valid, rx_overflow
    );

    modport slave (
        input  tx_data, tx_send, rx, rx_ready,
        output tx_busy, tx, rx_data, rx_parity_error, rx_framing_error, rx_valid, rx_overflow
    );
endinterface

// File: rtl/uart_framed.sv
// Full-duplex UART with configurable bit period, width, parity and stop bits.
// The receiver samples mid-bit, rejects false starts and queues {framing, parity, data} in a FIFO.
module uart_framed #(
    parameter int unsigned ClockDiv    = 434,
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned Parity      = 0,
    parameter int unsigned StopBits    = 1,
    parameter int unsigned RxFifoDepth = 4
) (
    input logic          clk_i,
    input logic          rst_i,
    uart_framed_if.slave bus_io
);
    localparam int unsigned CntW    = 16;
    localparam int unsigned IdxW    = 4;
    localparam int unsigned PtrW    = $clog2(RxFifoDepth);
    localparam int unsigned CountW  = PtrW + 1;
    localparam int unsigned EntW    = DataWidth + 2;
    localparam logic [CntW-1:0]   BitReload  = CntW'(ClockDiv - 1);
    localparam logic [CntW-1:0]   HalfReload = CntW'(ClockDiv / 2 - 1);
    localparam logic [IdxW-1:0]   LastData   = IdxW'(DataWidth - 1);
    localparam logic [IdxW-1:0]   LastStop   = IdxW'(StopBits - 1);
    localparam logic [CountW-1:0] CountFull  = CountW'(RxFifoDepth);
    localparam logic              OddParity  = (Parity == 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // ---------------- transmitter ----------------
    state_e               tx_state_q, tx_state_d;
    logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [IdxW-1:0]      tx_idx_q, tx_idx_d;
    logic [DataWidth-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_end;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_end     = (tx_cnt_q == '0);
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_end ? tx_cnt_q : tx_cnt_q - 1'b1;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            StIdle: begin
                if (bus_io.tx_send) begin
                    tx_state_d = StStart;
                    tx_cnt_d   = BitReload;
                    tx_shift_d = bus_io.tx_data;
                    tx_par_d   = (^bus_io.tx_data) ^ OddParity;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                if (tx_end) begin
                    tx_state_d = StData;
                    tx_cnt_d   = BitReload;
                    tx_idx_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
            end
            StData: begin
                if (tx_end) begin
                    tx_cnt_d = BitReload;
                    if (tx_idx_q == LastData) begin
                        tx_idx_d   = '0;
                        tx_state_d = (Parity != 0) ? StParity : StStop;
                        tx_d       = (Parity != 0) ? tx_par_q : 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            StParity: begin
                if (tx_end) begin
                    tx_state_d = StStop;
                    tx_cnt_d   = BitReload;
                    tx_d       = 1'b1;
                end
            end
            StStop: begin
                if (tx_end) begin
                    if (tx_idx_q == LastStop) begin
                        tx_state_d = StIdle;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                        tx_cnt_d = BitReload;
                    end
                end
            end
            default: tx_state_d = StIdle;
        endcase
    end

    assign bus_io.tx      = tx_q;
    assign bus_io.tx_busy = (tx_state_q != StIdle);

    // ---------------- receiver ----------------
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    state_e               rx_state_q, rx_state_d;
    logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [IdxW-1:0]      rx_idx_q, rx_idx_d;
    logic [DataWidth-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_end, rx_wr;
    logic [EntW-1:0]      rx_ent;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_s1_q    <= bus_io.rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    always_comb begin
        rx_end     = (rx_cnt_q == '0);
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_end ? rx_cnt_q : rx_cnt_q - 1'b1;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_wr      = 1'b0;
        rx_ent     = '0;
        unique case (rx_state_q)
            StIdle: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = StStart;
                    rx_cnt_d   = HalfReload;
                end
            end
            StStart: begin
                // Line back high at mid start bit: glitch, not a frame.
                if (rx_end) begin
                    rx_state_d = rx_s2_q ? StIdle : StData;
                    rx_cnt_d   = BitReload;
                    rx_idx_d   = '0;
                    rx_perr_d  = 1'b0;
                end
            end
            StData: begin
                if (rx_end) begin
                    rx_cnt_d   = BitReload;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DataWidth-1:1]};
                    if (rx_idx_q == LastData) begin
                        rx_state_d = (Parity != 0) ? StParity : StStop;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (rx_end) begin
                    rx_state_d = StStop;
                    rx_cnt_d   = BitReload;
                    rx_perr_d  = ((^rx_shift_q) ^ rx_s2_q) != OddParity;
                end
            end
            StStop: begin
                if (rx_end) begin
                    rx_state_d = StIdle;
                    rx_wr      = 1'b1;
                    rx_ent     = {~rx_s2_q, rx_perr_q, rx_shift_q};
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // ---------------- receive FIFO ----------------
    logic [EntW-1:0]   mem_q [RxFifoDepth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0] count_q;
    logic              ovf_q;
    logic              full, pop, push;
    logic [EntW-1:0]   head;

    assign full = (count_q == CountFull);
    assign pop  = (count_q != '0) && bus_io.rx_ready;
    assign push = rx_wr && (!full || pop);
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < RxFifoDepth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= rx_ent;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (rx_wr && full && !pop) ovf_q <= 1'b1;
        end
    end

    assign bus_io.rx_valid         = (count_q != '0);
    assign bus_io.rx_data          = head[DataWidth-1:0];
    assign bus_io.rx_parity_error  = head[DataWidth];
    assign bus_io.rx_framing_error = head[DataWidth+1];
    assign bus_io.rx_overflow      = ovf_q;
endmodule

// File: tb/tb_uart_framed.sv
// Bench for uart_framed: three instances (8N1, 8E2, 8O1) with ClockDiv = 16.
// Received frames are checked against a queue of expected {framing, parity, data} entries.
module tb_uart_framed;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [9:0] sb_q[$];

    always #5 clk = ~clk;

    uart_framed_if #(.DataWidth(8)) if_a ();
    uart_framed_if #(.DataWidth(8)) if_b ();
    uart_framed_if #(.DataWidth(8)) if_c ();

    assign if_a.rx       = 1'b1;
    assign if_a.rx_ready = 1'b1;
    assign if_b.rx       = 1'b1;
    assign if_b.rx_ready = 1'b1;
    assign if_c.rx       = loop_en ? if_c.tx : rx_drv;

    uart_framed #(.ClockDiv(16), .DataWidth(8), .Parity(0), .StopBits(1), .RxFifoDepth(4))
        u_a (.clk_i(clk), .rst_i(rst), .bus_io(if_a));
    uart_framed #(.ClockDiv(16), .DataWidth(8), .Parity(2), .StopBits(2), .RxFifoDepth(4))
        u_b (.clk_i(clk), .rst_i(rst), .bus_io(if_b));
    uart_framed #(.ClockDiv(16), .DataWidth(8), .Parity(1), .StopBits(1), .RxFifoDepth(4))
        u_c (.clk_i(clk), .rst_i(rst), .bus_io(if_c));

    // Expected line levels, one entry per bit period, starting with the start bit.
    function automatic logic [15:0] tx_frame(input logic [7:0] d, input int par, input int stops,
                                             output int len);
        logic [15:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (par != 0) begin
            bits[n] = (^d) ^ (par == 1);
            n++;
        end
        len = n + stops;
        return bits;
    endfunction

    // Drives one 8O1 frame on u_c's RX line, followed by one idle bit period.
    task automatic send_rx(input logic [7:0] d, input logic flip, input logic stop_val);
        logic [11:0] bits;
        bits = {1'b1, stop_val, (~^d) ^ flip, d, 1'b0};
        for (int i = 0; i < 12; i++) begin
            rx_drv = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic wait_rx_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (if_c.rx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pop_rx();
        if_c.rx_ready = 1'b1;
        @(negedge clk);
        if_c.rx_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        rx_drv = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [6:0] got;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got = {if_a.tx, if_a.tx_busy, if_c.rx_valid, if_c.rx_data == 8'h00,
               if_c.rx_parity_error, if_c.rx_framing_error, if_c.rx_overflow};
        checks++;
        if (got !== 7'b1001000) begin
            errors++;
            $display("FAIL reset_state got=%b want=1001000", got);
        end
        checks++;
        if (if_b.tx !== 1'b1 || if_b.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_b tx=%b busy=%b want tx=1 busy=0", if_b.tx, if_b.tx_busy);
        end
    endtask

    task automatic test_tx_8n1();
        logic [15:0] bits;
        int len;
        bits = tx_frame(8'hA5, 0, 1, len);
        if_a.tx_data = 8'hA5;
        if_a.tx_send = 1'b1;
        @(negedge clk);
        if_a.tx_send = 1'b0;
        for (int k = 0; k < len * 16; k++) begin
            checks++;
            if (if_a.tx !== bits[k/16] || if_a.tx_busy !== 1'b1) begin
                errors++;
                $display("FAIL tx_8n1 cycle %0d tx=%b busy=%b want tx=%b busy=1",
                         k, if_a.tx, if_a.tx_busy, bits[k/16]);
            end
            @(negedge clk);
        end
        checks++;
        if (if_a.tx !== 1'b1 || if_a.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL tx_8n1_end tx=%b busy=%b want tx=1 busy=0", if_a.tx, if_a.tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        logic [7:0] d [2];
        int len;
        d[0] = 8'h0F;
        d[1] = 8'h33;
        if_b.tx_data = d[0];
        if_b.tx_send = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            bits = tx_frame(d[f], 2, 2, len);
            for (int k = 0; k < len * 16; k++) begin
                if (f == 0 && k == 50) if_b.tx_data = d[1];
                if (f == 1 && k == 0) if_b.tx_send = 1'b0;
                checks++;
                if (if_b.tx !== bits[k/16] || if_b.tx_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_8e2 frame %0d cycle %0d tx=%b busy=%b want tx=%b busy=1",
                             f, k, if_b.tx, if_b.tx_busy, bits[k/16]);
                end
                @(negedge clk);
            end
            checks++;
            if (if_b.tx !== 1'b1 || if_b.tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL tx_8e2_gap frame %0d tx=%b busy=%b want tx=1 busy=0",
                         f, if_b.tx, if_b.tx_busy);
            end
            @(negedge clk);
        end
        checks++;
        if (if_b.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL tx_no_duplicate busy=%b want 0", if_b.tx_busy);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [4];
        logic [9:0] exp;
        logic [9:0] got;
        bit ok;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h55;
        bytes[3] = 8'h80;
        loop_en = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if_c.tx_data = bytes[b];
            if_c.tx_send = 1'b1;
            sb_q.push_back({2'b00, bytes[b]});
            @(negedge clk);
            if_c.tx_send = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (if_c.tx_busy === 1'b0) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL loopback_tx_timeout byte %0d busy=%b want 0", b, if_c.tx_busy);
            end
        end
        repeat (20) @(negedge clk);
        loop_en = 1'b0;
        while (sb_q.size() > 0) begin
            wait_rx_valid(ok);
            exp = sb_q.pop_front();
            got = {if_c.rx_framing_error, if_c.rx_parity_error, if_c.rx_data};
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL loopback valid=%b got=%h want=%h", if_c.rx_valid, got, exp);
            end
            if (ok) pop_rx();
        end
        checks++;
        if (if_c.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL loopback_empty valid=%b want 0", if_c.rx_valid);
        end
    endtask

    task automatic test_rx_errors();
        logic [9:0] exp;
        logic [9:0] got;
        bit ok;
        rx_drv = 1'b0;
        repeat (6) @(negedge clk);
        rx_drv = 1'b1;
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (if_c.rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL glitch_reject cycle %0d valid=%b want 0", i, if_c.rx_valid);
            end
            @(negedge clk);
        end
        sb_q.push_back({2'b10, 8'h3C});
        send_rx(8'h3C, 1'b0, 1'b0);
        sb_q.push_back({2'b01, 8'hC3});
        send_rx(8'hC3, 1'b1, 1'b1);
        while (sb_q.size() > 0) begin
            wait_rx_valid(ok);
            exp = sb_q.pop_front();
            got = {if_c.rx_framing_error, if_c.rx_parity_error, if_c.rx_data};
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL rx_error_flags valid=%b got=%h want=%h", if_c.rx_valid, got, exp);
            end
            if (ok) pop_rx();
        end
    endtask

    task automatic test_overflow();
        logic [9:0] exp;
        logic [9:0] got;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb_q.push_back({2'b00, 8'h11 + 8'(i)});
            send_rx(8'h11 + 8'(i), 1'b0, 1'b1);
        end
        checks++;
        if (if_c.rx_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set ovf=%b want 1", if_c.rx_overflow);
        end
        while (sb_q.size() > 0) begin
            wait_rx_valid(ok);
            exp = sb_q.pop_front();
            got = {if_c.rx_framing_error, if_c.rx_parity_error, if_c.rx_data};
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL overflow_retained valid=%b got=%h want=%h", if_c.rx_valid, got, exp);
            end
            if (ok) pop_rx();
        end
        checks++;
        if (if_c.rx_valid !== 1'b0 || if_c.rx_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky valid=%b ovf=%b want valid=0 ovf=1",
                     if_c.rx_valid, if_c.rx_overflow);
        end
        pulse_reset();
        // Fill, then pop exactly on the edge that writes a fifth frame.
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back({2'b00, 8'h31 + 8'(i)});
            send_rx(8'h31 + 8'(i), 1'b0, 1'b1);
        end
        sb_q.push_back({2'b00, 8'h35});
        fork
            send_rx(8'h35, 1'b0, 1'b1);
            begin
                repeat (170) @(negedge clk);
                exp = sb_q.pop_front();
                got = {if_c.rx_framing_error, if_c.rx_parity_error, if_c.rx_data};
                checks++;
                if (if_c.rx_valid !== 1'b1 || got !== exp) begin
                    errors++;
                    $display("FAIL full_pop_head valid=%b got=%h want=%h",
                             if_c.rx_valid, got, exp);
                end
                pop_rx();
            end
        join
        checks++;
        if (if_c.rx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_write ovf=%b want 0", if_c.rx_overflow);
        end
        while (sb_q.size() > 0) begin
            wait_rx_valid(ok);
            exp = sb_q.pop_front();
            got = {if_c.rx_framing_error, if_c.rx_parity_error, if_c.rx_data};
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL full_pop_order valid=%b got=%h want=%h", if_c.rx_valid, got, exp);
            end
            if (ok) pop_rx();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] got;
        logic [9:0] exp;
        logic [9:0] rx_got;
        bit ok;
        int busy_cycles;
        send_rx(8'h21, 1'b0, 1'b1);
        if_a.tx_data = 8'h5A;
        if_a.tx_send = 1'b1;
        @(negedge clk);
        if_a.tx_send = 1'b0;
        rx_drv = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        rx_drv = 1'b1;
        @(negedge clk);
        got = {if_a.tx, if_a.tx_busy, if_c.rx_valid, if_c.rx_overflow};
        checks++;
        if (got !== 4'b1000) begin
            errors++;
            $display("FAIL reset_mid_frame got tx,busy,valid,ovf=%b want 1000", got);
        end
        rst = 1'b0;
        sb_q.delete();
        repeat (20) @(negedge clk);
        checks++;
        if (if_c.rx_valid !== 1'b0 || if_a.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_residue valid=%b busy=%b want 0 0",
                     if_c.rx_valid, if_a.tx_busy);
        end
        sb_q.push_back({2'b00, 8'h42});
        send_rx(8'h42, 1'b0, 1'b1);
        wait_rx_valid(ok);
        exp = sb_q.pop_front();
        rx_got = {if_c.rx_framing_error, if_c.rx_parity_error, if_c.rx_data};
        checks++;
        if (!ok || rx_got !== exp) begin
            errors++;
            $display("FAIL after_reset_rx valid=%b got=%h want=%h", if_c.rx_valid, rx_got, exp);
        end
        if (ok) pop_rx();
        if_a.tx_send = 1'b1;
        @(negedge clk);
        if_a.tx_send = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            if (if_a.tx_busy !== 1'b1) break;
            busy_cycles++;
            @(negedge clk);
        end
        checks++;
        if (busy_cycles != 160) begin
            errors++;
            $display("FAIL after_reset_tx busy cycles=%0d want 160", busy_cycles);
        end
    endtask

    initial begin
        if_a.tx_data = '0;
        if_a.tx_send = 1'b0;
        if_b.tx_data = '0;
        if_b.tx_send = 1'b0;
        if_c.tx_data = '0;
        if_c.tx_send = 1'b0;
        if_c.rx_ready = 1'b0;
        test_reset();
        test_tx_8n1();
        test_back_to_back();
        test_loopback();
        test_rx_errors();
        test_overflow();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_framed.md
# uart_framed

Parametrised full-duplex UART for the practical designs: configurable bit period, data width, parity and stop bits. The transmitter takes a level send handshake. The receiver has a false-start reject, a mid-bit sampler and parity/framing checks, and writes into a small FIFO read with valid/ready. It sits between the board RX/TX pins and the packet/register logic, and replaces the fixed 8N1 UART.

## Interface
- CLOCK_DIV, 434: ipClk cycles per bit; legal range 16..65535 (434 gives 115 200 Bd at 50 MHz).
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2; applies to TX framing only.
- RX_FIFO_DEPTH, 4: receive FIFO entries; power of two, minimum 2.
- ipClk  in  1  the only clock.
- ipReset  in  1  synchronous, active-high reset.
- ipTxData  in  DATA_WIDTH  byte to send; sampled on the accept cycle.
- ipTxSend  in  1  send request (level).
- opTxBusy  out  1  transmitter busy.
- opTx  out  1  serial out; idle high.
- ipRx  in  1  serial in; asynchronous.
- opRxData  out  DATA_WIDTH  FIFO head data.
- opRxParityError  out  1  FIFO head had a parity mismatch; 0 when PARITY = 0.
- opRxFramingError  out  1  FIFO head had stop bit sampled 0.
- opRxValid  out  1  FIFO not empty.
- ipRxReady  in  1  consumer pops the head when high with opRxValid.
- opRxOverflow  out  1  sticky: a frame was dropped because the FIFO was full.

## Operation
- Reset values: opTx = 1, opTxBusy = 0, opRxValid = 0, opRxData = 0, both error flags 0, opRxOverflow = 0. Reset also clears the FIFO and puts both FSMs in IDLE.
- Reset mid-frame aborts the frame. opTx is high on the edge after ipReset is sampled.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - Accept happens on the edge where the FSM is in IDLE and ipTxSend = 1. On that edge ipTxData is latched, opTxBusy goes to 1 and opTx goes to 0 (start bit).
  - Each bit is held for exactly CLOCK_DIV cycles, using a bit-period down-counter reloaded on every bit.
  - Bit order: start 0, data LSB first, parity bit (skipped when PARITY = 0), then STOP_BITS bits of 1.
  - Parity bit: XOR of the data bits for even; its complement for odd.
- RX input: ipRx passes through a 2-flop synchroniser; all RX logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a 1→0 transition of the synchronised line; the counter loads CLOCK_DIV/2 − 1 (integer division).
  - At START expiry: if the line is 1, it is a false start and the FSM returns to IDLE with nothing written. Otherwise subsequent samples are taken every CLOCK_DIV cycles (mid-bit).
  - Parity is checked against the received data.
  - Only the first stop bit is checked; a 0 sets the framing error.
  - At the stop-bit sample the entry {framing, parity, data} is written to the FIFO and the FSM returns to IDLE on that same edge, so it is ready for a new start immediately.
  - Framing-error frames are still written to the FIFO.
- FIFO behaviour:
  - opRxData and both error flags are combinational from the head entry.
  - Pop occurs when opRxValid & ipRxReady.
  - Write while full with a simultaneous pop: the write succeeds and count is unchanged.
  - Write while full with no pop: the frame is dropped and opRxOverflow sets until reset.
  - Read/write pointers wrap modulo RX_FIFO_DEPTH. A separate count, or an extra pointer bit, distinguishes full from empty.

## Timing
- TX frame length is (1 + DATA_WIDTH + (PARITY≠0) + STOP_BITS) × CLOCK_DIV cycles, measured from the accept edge.
- opTxBusy returns to 0 on the edge ending the last stop bit and stays 0 for at least one cycle. If ipTxSend is still 1 at that point, the next frame is accepted on the following edge, so no send is missed and no send is duplicated within a frame.
- ipTxData changes while busy have no effect on the current frame.
- RX latency: the FIFO write happens 2 (synchroniser) + 1 (edge detect) + CLOCK_DIV/2 + (DATA_WIDTH + (PARITY≠0) + 1) × CLOCK_DIV cycles after the ipRx falling edge. opRxValid is 1 on the edge after that write.
- A pop updates the head on the next edge. opRxValid falls on the next edge when the FIFO becomes empty.

## Test plan
- Use CLOCK_DIV = 16. TX of 0xA5 with 8N1 → opTx shows 0,1,0,1,0,0,1,0,1,1, each bit for 16 cycles. opTxBusy is high for 160 cycles.
- TX of 0x0F with even parity and STOP_BITS = 2 → the parity bit is 0; busy is high for 192 cycles. Hold ipTxSend high → the second frame starts exactly one cycle after busy falls.
- Loopback opTx→ipRx for bytes 0x00, 0xFF, 0x55, 0x80 with odd parity → each is read back with both error flags 0, in order.
- RX with a 6-cycle low glitch → no FIFO write and opRxValid stays 0. A frame whose stop bit is 0 → the data is delivered with opRxFramingError = 1. A flipped parity bit → opRxParityError = 1.
- Hold ipRxReady = 0 and send RX_FIFO_DEPTH + 1 frames → the first 4 are retained and opRxOverflow = 1. Pop and write on the same cycle while full → no overflow.
- Assert ipReset mid-TX and mid-RX frame → on the next edge opTx = 1, opTxBusy = 0, opRxValid = 0. Operation is normal afterwards.
